bus_byte_packer: RTL

BUS_BYTE_PACKER -- requirements
Module: bus_byte_packer

---
 rtl/bus_pkg.sv | 31 +++
 rtl/bus_fifo.sv | 52 +++++
 rtl/bus_byte_packer.sv | 101 ++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared types for the byte-stream to bus-frame packer.
// One frame is twelve bytes carrying adr, dat and sel words.
package bus_pkg;

  localparam int FRAME_BYTES = 12;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [31:0] sel;
  } t_bus;

  typedef enum logic [1:0] {
    IDLE,
    ADR,
    DAT,
    SEL
  } t_state;

  // Flat little-endian byte vector: byte i sits at [8i+7:8i].
  function automatic t_bus pack_frame(
    input logic [8*FRAME_BYTES-1:0] f
  );
    t_bus b;
    b.adr = f[31:0];
    b.dat = f[63:32];
    b.sel = f[95:64];
    return b;
  endfunction

endpackage

// File: rtl/bus_fifo.sv
// Small synchronous FIFO with wrap-bit pointers.
// Push while full is honoured only alongside a pop.
module bus_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  assign wr_d = do_push ? wr_q + 1'b1 : wr_q;
  assign rd_d = do_pop ? rd_q + 1'b1 : rd_q;

  // Empty reads as zero so the output bus is clean after reset.
  assign dout_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/bus_byte_packer.sv
// Packs a sof-delimited byte stream into 96-bit bus frames
// and buffers them behind a valid/ready output.
module bus_byte_packer
  import bus_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        in_sof,
  input  logic [7:0]  in_byte,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output t_bus        out_bus,
  output logic [15:0] frame_cnt,
  output logic        err
);

  localparam int HB = 8 * (FRAME_BYTES - 1);

  t_state        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [HB-1:0] frame_q, frame_d;
  logic          err_q, err_d;
  logic [15:0]   cnt_q;
  logic          push;
  logic          pop;
  logic          acc;
  logic          fifo_full;
  logic          fifo_empty;
  t_bus          push_data;

  assign pop       = out_valid && out_ready;
  assign in_ready  = !((idx_q == 4'd11) && fifo_full && !pop);
  assign acc       = in_valid && in_ready;
  assign push_data = pack_frame({in_byte, frame_q});
  assign out_valid = !fifo_empty;
  assign frame_cnt = cnt_q;
  assign err       = err_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    frame_d = frame_q;
    err_d   = err_q;
    push    = 1'b0;
    if (acc) begin
      if (in_sof) begin
        // A sof mid-frame drops the partial and restarts here.
        if (state_q != IDLE) err_d = 1'b1;
        frame_d[7:0] = in_byte;
        state_d      = ADR;
        idx_d        = 4'd1;
      end else if (state_q == IDLE) begin
        err_d = 1'b1;
      end else if (idx_q == 4'd11) begin
        push    = 1'b1;
        state_d = IDLE;
        idx_d   = 4'd0;
      end else begin
        frame_d[idx_q*8 +: 8] = in_byte;
        idx_d                 = idx_q + 4'd1;
        if (idx_q == 4'd3) state_d = DAT;
        if (idx_q == 4'd7) state_d = SEL;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      frame_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      err_q   <= err_d;
      if (pop) cnt_q <= cnt_q + 16'd1;
    end
  end

  bus_fifo #(
    .WIDTH ($bits(t_bus)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .din_i   (push_data),
    .pop_i   (pop),
    .dout_o  (out_bus),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule
